// File: rtl/muldiv_unit_if.sv
// Handshake and data bundle between the LEGv8 core and muldiv_unit.
// The core drives the request side (master); the unit answers on the slave side.
interface muldiv_unit_if #(
    parameter int WIDTH    = 64,
    parameter int REG_BITS = 5
);
    logic                start;
    logic [2:0]          op;
    logic [WIDTH-1:0]    operand_a;
    logic [WIDTH-1:0]    operand_b;
    logic [REG_BITS-1:0] dest_reg_in;
    logic                busy;
    logic                done;
    logic [WIDTH-1:0]    result;
    logic [REG_BITS-1:0] dest_reg_out;
    logic                div_by_zero;

    modport master (
        output start, op, operand_a, operand_b, dest_reg_in,
        input  busy, done, result, dest_reg_out, div_by_zero
    );

    modport slave (
        input  start, op, operand_a, operand_b, dest_reg_in,
        output busy, done, result, dest_reg_out, div_by_zero
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide (MUL, UMULH, SMULH, UDIV, SDIV): shift-add multiply and restoring divide.
// Optional MULDIV_ZERO_SKIP_EN lets a zero operand bypass the RUN phase.
module muldiv_unit #(
    parameter int WIDTH    = 64,
    parameter int REG_BITS = 5
) (
    input  logic           clk,
    input  logic           reset,
    muldiv_unit_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_MUL   = 3'b000;
    localparam logic [2:0] OP_UMULH = 3'b001;
    localparam logic [2:0] OP_SMULH = 3'b010;
    localparam logic [2:0] OP_UDIV  = 3'b011;
    localparam logic [2:0] OP_SDIV  = 3'b100;

    typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN, S_DONE} state_t;

    state_t              r_state, w_stateNext;
    logic [CW-1:0]       r_count;
    logic [2:0]          r_op;
    logic [WIDTH-1:0]    r_a, r_b, r_m;
    logic [2*WIDTH-1:0]  r_acc, w_accNext, w_signedAcc;
    logic                r_neg;
    logic [REG_BITS-1:0] r_dest, r_destOut;
    logic [WIDTH-1:0]    r_result, w_final;
    logic                r_divZero;

    logic             w_busy, w_done, w_accept;
    logic             w_isMul, w_isDiv, w_isSigned, w_aNeg, w_bNeg, w_divZero;
    logic [WIDTH-1:0] w_aMag, w_bMag;
    logic [WIDTH:0]   w_shifted, w_diff, w_sum;
`ifdef MULDIV_ZERO_SKIP_EN
    logic             w_zeroOperand;
    assign w_zeroOperand = (r_a == '0) || (r_b == '0);
`endif

    assign w_accept   = bus.start && !w_busy;
    assign w_isMul    = (r_op == OP_MUL) || (r_op == OP_UMULH) || (r_op == OP_SMULH);
    assign w_isDiv    = (r_op == OP_UDIV) || (r_op == OP_SDIV);
    assign w_isSigned = (r_op == OP_SMULH) || (r_op == OP_SDIV);
    assign w_aNeg     = w_isSigned && r_a[WIDTH-1];
    assign w_bNeg     = w_isSigned && r_b[WIDTH-1];
    assign w_aMag     = w_aNeg ? -r_a : r_a;
    assign w_bMag     = w_bNeg ? -r_b : r_b;
    assign w_divZero  = w_isDiv && (r_b == '0);

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_stateNext;
    end

    always_comb begin
        w_stateNext = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: if (bus.start) w_stateNext = S_PREP;
            S_PREP: begin
                w_busy = 1'b1;
`ifdef MULDIV_ZERO_SKIP_EN
                w_stateNext = w_zeroOperand ? S_DONE : S_RUN;
`else
                w_stateNext = S_RUN;
`endif
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (r_count == CW'(WIDTH-1)) w_stateNext = S_DONE;
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_stateNext = bus.start ? S_PREP : S_IDLE;
            end
            default: w_stateNext = S_IDLE;
        endcase
    end

    // One shared accumulator: {product-high, multiplier} for multiply, {remainder, dividend/quotient} for divide.
    always_comb begin
        w_accNext = r_acc;
        w_shifted = r_acc[2*WIDTH-1:WIDTH-1];
        w_diff    = w_shifted - {1'b0, r_m};
        w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_m} : '0);
        case (r_state)
            S_PREP: begin
                w_accNext = {{WIDTH{1'b0}}, (w_isMul ? w_bMag : w_aMag)};
`ifdef MULDIV_ZERO_SKIP_EN
                if (w_zeroOperand) w_accNext = '0;
`endif
            end
            S_RUN: begin
                if (!w_isDiv)
                    w_accNext = {w_sum, r_acc[WIDTH-1:1]};
                else if (!w_diff[WIDTH])
                    w_accNext = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
                else
                    w_accNext = {r_acc[2*WIDTH-2:WIDTH-1], r_acc[WIDTH-2:0], 1'b0};
            end
            default: ;
        endcase
    end

    // Final value is formed from the accumulator's next state so it is registered as DONE begins.
    always_comb begin
        w_signedAcc = r_neg ? -w_accNext : w_accNext;
        w_final     = '0;
        case (r_op)
            OP_MUL:            w_final = w_signedAcc[WIDTH-1:0];
            OP_UMULH, OP_SMULH: w_final = w_signedAcc[2*WIDTH-1:WIDTH];
            OP_UDIV, OP_SDIV:  w_final = w_divZero ? '0 : w_signedAcc[WIDTH-1:0];
            default:           w_final = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count   <= '0;
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_m       <= '0;
            r_acc     <= '0;
            r_neg     <= 1'b0;
            r_dest    <= '0;
            r_destOut <= '0;
            r_result  <= '0;
            r_divZero <= 1'b0;
        end else begin
            r_acc <= w_accNext;
            if (w_accept) begin
                r_op   <= bus.op;
                r_a    <= bus.operand_a;
                r_b    <= bus.operand_b;
                r_dest <= bus.dest_reg_in;
            end
            if (r_state == S_PREP) begin
                r_m     <= w_isMul ? w_aMag : w_bMag;
                r_neg   <= w_aNeg ^ w_bNeg;
                r_count <= '0;
            end
            if (r_state == S_RUN) r_count <= r_count + 1'b1;
            if (w_stateNext == S_DONE && r_state != S_DONE) begin
                r_result  <= w_final;
                r_destOut <= r_dest;
                r_divZero <= w_divZero;
            end
        end
    end

    assign bus.busy         = w_busy;
    assign bus.done         = w_done;
    assign bus.result       = r_result;
    assign bus.dest_reg_out = r_destOut;
    assign bus.div_by_zero  = r_divZero;
endmodule
